event_recorder: RTL and testbench

- Clocked capture stage downstream of the event-ordering examples.
- Samples three VAL_W-bit watched signals (a, b, c) every clock and detects any value change.
- Timestamps each change and queues it in a small FWFT FIFO; a monitor/log consumer drains it via valid/ready.
- Gives the simulator test suite a cycle-accurate, checkable record of all events.

---
 rtl/event_recorder_if.sv | 36 +++
 rtl/event_recorder.sv | 143 ++++++++++++++
 tb/tb_event_recorder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/event_recorder_if.sv
`default_nettype none
// ============================================================================
//  Module      : event_recorder_if
//  Description : Output stream of the event recorder. The recorder drives the
//                head entry, its valid flag and the occupancy; the log
//                consumer returns ready.
//  Ports       : out_valid - head entry available
//                out_ready - consumer accepts head entry this cycle
//                out_data  - head entry {ts, mask, a, b, c}
//                out_count - current FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
interface event_recorder_if #(
  parameter int DATA_W = 25,
  parameter int CNT_W  = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output out_valid,
    output out_data,
    output out_count,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_count,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/event_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : event_recorder
//  Description : Samples three watched signals every clock, timestamps any
//                change and queues it in a first-word-fall-through FIFO that
//                a log consumer drains through a valid/ready stream.
//  Ports       : clk      - clock, all state updates on posedge
//                rst      - asynchronous active-high reset
//                en       - capture enable (baseline still tracks when 0)
//                a, b, c  - watched signals
//                out_if   - master side of the output stream
//                overflow - sticky, an event was dropped on a full FIFO
//                clr_ovf  - synchronous clear of overflow and drop_cnt
//                drop_cnt - dropped-event count, saturates at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module event_recorder #(
  parameter int VAL_W = 2,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [VAL_W-1:0] a,
  input  logic [VAL_W-1:0] b,
  input  logic [VAL_W-1:0] c,
  event_recorder_if.master out_if,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [7:0]       drop_cnt
);

  localparam int DATA_W = TS_W + 3 + 3 * VAL_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Registered state
  logic [TS_W-1:0]   ts_q,       ts_d;
  logic [VAL_W-1:0]  prev_a_q,   prev_a_d;
  logic [VAL_W-1:0]  prev_b_q,   prev_b_d;
  logic [VAL_W-1:0]  prev_c_q,   prev_c_d;
  logic              armed_q,    armed_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [DATA_W-1:0] fifo_mem [DEPTH];

  // Per-cycle decode
  logic [2:0]        chg_mask;
  logic              evt;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] entry;

  always_comb begin
    // Nothing is compared until the baseline sample has been taken.
    chg_mask = '0;
    if (armed_q) begin
      chg_mask[0] = (a != prev_a_q);
      chg_mask[1] = (b != prev_b_q);
      chg_mask[2] = (c != prev_c_q);
    end
    evt   = |chg_mask;
    full  = (count_q == CNT_W'(DEPTH));
    pop   = (count_q != '0) && out_if.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push  = evt && en && (!full || pop);
    drop  = evt && en && full && !pop;
    entry = {ts_q, chg_mask, a, b, c};
  end

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    prev_a_d   = a;
    prev_b_d   = b;
    prev_c_d   = c;
    armed_d    = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Clear takes priority over a drop landing in the same cycle.
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      prev_c_q   <= '0;
      armed_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_a_q   <= prev_a_d;
      prev_b_q   <= prev_b_d;
      prev_c_q   <= prev_c_d;
      armed_q    <= armed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= entry;
  end

  // Head is forced to zero while empty so the reset value is well defined.
  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_count = count_q;
  assign out_if.out_data  = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
  assign overflow         = overflow_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_event_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_recorder
//  Description : Self-checking bench for event_recorder. Two instances share
//                all stimulus: one with a 16-bit timestamp and one with a
//                4-bit timestamp, so the wrap case is seen on the second.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_recorder;

  localparam int VAL_W = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DW16  = 16 + 3 + 3 * VAL_W;
  localparam int DW4   = 4 + 3 + 3 * VAL_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [VAL_W-1:0] in_a = '0;
  logic [VAL_W-1:0] in_b = '0;
  logic [VAL_W-1:0] in_c = '0;
  logic             rdy = 1'b0;
  logic             clr = 1'b0;
  logic             ovf16, ovf4;
  logic [7:0]       drop16, drop4;

  event_recorder_if #(.DATA_W(DW16), .CNT_W(CNT_W)) if16 ();
  event_recorder_if #(.DATA_W(DW4),  .CNT_W(CNT_W)) if4 ();

  assign if16.out_ready = rdy;
  assign if4.out_ready  = rdy;

  event_recorder #(.VAL_W(VAL_W), .TS_W(16), .DEPTH(DEPTH)) dut16 (
    .clk(clk), .rst(rst), .en(en), .a(in_a), .b(in_b), .c(in_c),
    .out_if(if16), .overflow(ovf16), .clr_ovf(clr), .drop_cnt(drop16)
  );

  event_recorder #(.VAL_W(VAL_W), .TS_W(4), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .en(en), .a(in_a), .b(in_b), .c(in_c),
    .out_if(if4), .overflow(ovf4), .clr_ovf(clr), .drop_cnt(drop4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    logic [1:0] a, b, c;
    bit         en, rdy, clr;
    bit         exp_valid;
    int         exp_count;
    bit         exp_ovf;
    int         exp_drop;
  } vec_t;

  typedef struct {
    logic [15:0] ts;
    logic [2:0]  mask;
    logic [1:0]  a, b, c;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Reference state for the timestamp / baseline, used to build entries
  logic [15:0] m_ts;
  logic [1:0]  m_pa, m_pb, m_pc;
  bit          m_armed;

  function automatic vec_t mk(bit r, logic [1:0] a, logic [1:0] b, logic [1:0] c,
                              bit e, bit rd, bit cl, bit ev, int ec, bit eo, int ed);
    vec_t v;
    v.rst_before = r; v.a = a; v.b = b; v.c = c;
    v.en = e; v.rdy = rd; v.clr = cl;
    v.exp_valid = ev; v.exp_count = ec; v.exp_ovf = eo; v.exp_drop = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, n_vec, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input bit v, input int cnt, input bit o, input int d);
    chk({tag, "_valid16"}, 64'(if16.out_valid), 64'(v));
    chk({tag, "_count16"}, 64'(if16.out_count), 64'(cnt));
    chk({tag, "_ovf16"},   64'(ovf16),          64'(o));
    chk({tag, "_drop16"},  64'(drop16),         64'(d));
    chk({tag, "_valid4"},  64'(if4.out_valid),  64'(v));
    chk({tag, "_count4"},  64'(if4.out_count),  64'(cnt));
    chk({tag, "_ovf4"},    64'(ovf4),           64'(o));
    chk({tag, "_drop4"},   64'(drop4),          64'(d));
  endtask

  task automatic apply(input vec_t v);
    ent_t e;
    bit   popping;
    logic [2:0] mask;
    @(negedge clk);
    if (v.rst_before) begin
      rst = 1'b1;
      #1;
      chk_state("reset", 1'b0, 0, 1'b0, 0);
      chk("reset_data16", 64'(if16.out_data), 64'd0);
      sb.delete();
      m_ts = '0; m_pa = '0; m_pb = '0; m_pc = '0; m_armed = 1'b0;
      #1 rst = 1'b0;
    end
    in_a = v.a; in_b = v.b; in_c = v.c;
    en = v.en; rdy = v.rdy; clr = v.clr;
    #1;
    popping = (sb.size() != 0) && v.rdy;
    if (popping) begin
      e = sb.pop_front();
      chk("pop_valid16", 64'(if16.out_valid), 64'd1);
      chk("pop_data16",  64'(if16.out_data),  64'({e.ts, e.mask, e.a, e.b, e.c}));
      chk("pop_data4",   64'(if4.out_data),   64'({e.ts[3:0], e.mask, e.a, e.b, e.c}));
    end
    mask = m_armed ? {v.c != m_pc, v.b != m_pb, v.a != m_pa} : 3'b000;
    if (mask != 3'b000 && v.en && (sb.size() < DEPTH)) begin
      e.ts = m_ts; e.mask = mask; e.a = v.a; e.b = v.b; e.c = v.c;
      sb.push_back(e);
    end
    m_pa = v.a; m_pb = v.b; m_pc = v.c; m_armed = 1'b1; m_ts = m_ts + 16'd1;
    @(posedge clk);
    #1;
    chk_state("post", v.exp_valid, v.exp_count, v.exp_ovf, v.exp_drop);
    n_vec++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Baseline, single event, en=0 suppression
    vecs.push_back(mk(1, 0,0,0, 1,0,0, 0,0,0,0));
    for (int i = 1; i < 5; i++) vecs.push_back(mk(0, 0,0,0, 1,0,0, 0,0,0,0));
    vecs.push_back(mk(0, 1,0,0, 1,0,0, 1,1,0,0));   // ts=5, mask 001
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 0,0,0,0));   // pop it
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0,0));   // change with en=0

    // Multi-bit changes and ordering
    vecs.push_back(mk(1, 0,0,0, 1,0,0, 0,0,0,0));
    for (int i = 1; i < 4; i++) vecs.push_back(mk(0, 0,0,0, 1,0,0, 0,0,0,0));
    vecs.push_back(mk(0, 1,0,0, 1,0,0, 1,1,0,0));   // ts=4 mask 001
    vecs.push_back(mk(0, 1,3,3, 1,0,0, 1,2,0,0));   // ts=5 mask 110
    vecs.push_back(mk(0, 1,3,0, 1,0,0, 1,3,0,0));   // ts=6 mask 100
    vecs.push_back(mk(0, 1,3,0, 1,1,0, 1,2,0,0));
    vecs.push_back(mk(0, 1,3,0, 1,1,0, 1,1,0,0));
    vecs.push_back(mk(0, 1,3,0, 1,1,0, 0,0,0,0));
    vecs.push_back(mk(0, 1,3,0, 1,0,0, 0,0,0,0));

    // Overflow, clear, full push+pop, clear-vs-drop, saturation
    vecs.push_back(mk(1, 0,0,0, 1,0,0, 0,0,0,0));
    for (int i = 1; i <= 10; i++)
      vecs.push_back(mk(0, 2'(i % 2),0,0, 1,0,0, 1, (i < 8) ? i : 8,
                        (i > 8), (i > 8) ? i - 8 : 0));
    vecs.push_back(mk(0, 0,0,0, 1,0,1, 1,8,0,0));   // clear only
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 1,8,0,0));   // full, pop + push
    vecs.push_back(mk(0, 0,0,0, 1,0,1, 1,8,0,0));   // drop and clear together
    for (int i = 0; i < 260; i++)
      vecs.push_back(mk(0, (i % 2 == 0) ? 2'd1 : 2'd0,0,0, 1,0,0, 1,8,1,
                        (i + 1 < 255) ? i + 1 : 255));
    vecs.push_back(mk(0, 0,0,0, 1,0,1, 1,8,0,0));
    vecs.push_back(mk(0, 1,0,0, 0,0,0, 1,8,0,0));   // en=0 on full: no drop

    // Timestamp wrap (4-bit instance) and reset mid-queue
    vecs.push_back(mk(1, 0,0,0, 1,0,0, 0,0,0,0));
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(0, 0,0,0, 1,0,0, 0,0,0,0));
    vecs.push_back(mk(0, 1,0,0, 1,0,0, 1,1,0,0));   // ts=17
    vecs.push_back(mk(0, 2,0,0, 1,0,0, 1,2,0,0));   // ts=18
    vecs.push_back(mk(0, 2,0,0, 1,1,0, 1,1,0,0));   // pop ts=17 entry
    vecs.push_back(mk(1, 3,1,0, 1,0,0, 0,0,0,0));   // reset, baseline on nonzero
    vecs.push_back(mk(0, 3,1,0, 1,0,0, 0,0,0,0));
    vecs.push_back(mk(0, 3,1,1, 1,0,0, 1,1,0,0));   // ts=2 mask 100
    vecs.push_back(mk(0, 3,1,1, 1,1,0, 0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
